// File: rtl/mul_scheduler.sv
// Round-robin scheduler sharing one multiplier among REQ requesters.
// One operation in flight; registered response with backpressure.
module mul_scheduler #(
    parameter  int BUS = 4,
    parameter  int REQ = 4,
    localparam int IDW = $clog2(REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REQ-1:0]       req_valid_i,
    input  logic [REQ*BUS-1:0]   req_a_i,
    input  logic [REQ*BUS-1:0]   req_b_i,
    output logic [REQ-1:0]       req_ready_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IDW-1:0]       rsp_id_o,
    output logic [BUS-1:0]       rsp_result_o,
    output logic                 rsp_overflow_o,
    output logic                 rsp_zero_o,
    output logic                 rsp_negative_o,
    output logic                 rsp_carry_out_o
);

    localparam int SW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [BUS-1:0]   a_q, a_d;
    logic [BUS-1:0]   b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             rvalid_q, rvalid_d;
    logic [IDW-1:0]   rid_q, rid_d;
    logic [BUS-1:0]   res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             cy_q, cy_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic [SW-1:0]    s;
    logic             can_accept;
    logic             grant;
    logic [BUS-1:0]   op_a;
    logic [BUS-1:0]   op_b;
    logic [2*BUS-1:0] prod;

    // Search ptr, ptr+1, ... wrapping modulo REQ; first valid wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        s     = '0;
        for (int i = 0; i < REQ; i++) begin
            s = {1'b0, ptr_q} + SW'(i);
            if (s >= SW'(REQ)) begin
                s = s - SW'(REQ);
            end
            if (!found && req_valid_i[s[IDW-1:0]]) begin
                found = 1'b1;
                win   = s[IDW-1:0];
            end
        end
    end

    assign can_accept = (state_q == IDLE) ||
                        ((state_q == DONE) && rsp_ready_i);
    // Gated by rst_n so no grant escapes while reset is held.
    assign grant       = can_accept && found && rst_n;
    assign req_ready_o = grant ? (REQ'(1) << win) : '0;

    assign op_a = req_a_i[int'(win)*BUS +: BUS];
    assign op_b = req_b_i[int'(win)*BUS +: BUS];
    assign prod = {{BUS{1'b0}}, a_q} * {{BUS{1'b0}}, b_q};

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        a_d      = a_q;
        b_d      = b_q;
        id_d     = id_q;
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        cy_d     = cy_q;
        if (grant) begin
            a_d   = op_a;
            b_d   = op_b;
            id_d  = win;
            ptr_d = (win == IDW'(REQ-1)) ? '0 : win + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d  = DONE;
                rvalid_d = 1'b1;
                rid_d    = id_q;
                res_d    = prod[BUS-1:0];
                ovf_d    = (a_q != '0) && (prod[2*BUS-1:BUS] != '0);
                zero_d   = (a_q == '0) || (b_q == '0);
                neg_d    = prod[BUS-1];
                cy_d     = prod[BUS];
            end
            DONE: begin
                if (rsp_ready_i) begin
                    rvalid_d = 1'b0;
                    state_d  = grant ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            cy_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            cy_q     <= cy_d;
        end
    end

    assign rsp_valid_o     = rvalid_q;
    assign rsp_id_o        = rid_q;
    assign rsp_result_o    = res_q;
    assign rsp_overflow_o  = ovf_q;
    assign rsp_zero_o      = zero_q;
    assign rsp_negative_o  = neg_q;
    assign rsp_carry_out_o = cy_q;

endmodule

// File: tb/tb_mul_scheduler.sv
// Randomized bench for mul_scheduler against a plain-arithmetic model.
// Each scenario task does its own inline comparisons.
module tb_mul_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_result;
    logic        rsp_overflow;
    logic        rsp_zero;
    logic        rsp_negative;
    logic        rsp_carry_out;

    int vectors;
    int miscompares;
    int m_ptr;
    logic [9:0] sb[$];

    mul_scheduler #(.BUS(4), .REQ(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_a_i        (req_a),
        .req_b_i        (req_b),
        .req_ready_o    (req_ready),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_id_o       (rsp_id),
        .rsp_result_o   (rsp_result),
        .rsp_overflow_o (rsp_overflow),
        .rsp_zero_o     (rsp_zero),
        .rsp_negative_o (rsp_negative),
        .rsp_carry_out_o(rsp_carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {overflow, zero, negative, carry, result[3:0]}
    function automatic logic [7:0] model(input int a, input int b);
        int p, res;
        p   = a * b;
        res = p % 16;
        return {1'b0 + ((a != 0) && (p >= 16)),
                1'b0 + ((a == 0) || (b == 0)),
                1'b0 + (res >= 8),
                1'b0 + ((p / 16) % 2 == 1),
                4'(res)};
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) begin
            if (v[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] obs();
        return {rsp_overflow, rsp_zero, rsp_negative,
                rsp_carry_out, rsp_result};
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        m_ptr = 0;
        sb.delete();
    endtask

    task automatic one_op(input int r, input int a, input int b,
                          output logic [3:0] rdy, output logic v,
                          output logic [1:0] id, output logic [7:0] f);
        req_a[r*4 +: 4] = 4'(a);
        req_b[r*4 +: 4] = 4'(b);
        req_valid       = 4'b0001 << r;
        #1;
        rdy = req_ready;
        sync();
        req_valid = '0;
        sync();
        v  = rsp_valid;
        id = rsp_id;
        f  = obs();
        sync();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #2;
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ready got=%b want=0000", req_ready);
        end
        vectors++;
        if ({rsp_valid, rsp_id, obs()} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_rsp got=%b want=0",
                     {rsp_valid, rsp_id, obs()});
        end
        sync();
        req_valid = '0;
        rst_n     = 1'b1;
        m_ptr     = 0;
        sync();
    endtask

    task automatic test_single();
        req_a[8 +: 4] = 4'd3;
        req_b[8 +: 4] = 4'd5;
        req_valid     = 4'b0100;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ready got=%b want=0100", req_ready);
        end
        sync();
        req_valid = '0;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_exec_valid got=%b want=0", rsp_valid);
        end
        sync();
        vectors++;
        if ({rsp_valid, rsp_id, obs()} !== {1'b1, 2'd2, 8'b0010_1111}) begin
            miscompares++;
            $display("FAIL single_rsp got=%b want=%b",
                     {rsp_valid, rsp_id, obs()}, {1'b1, 2'd2, 8'b0010_1111});
        end
        sync();
    endtask

    task automatic test_arith();
        int ta[$];
        int tb[$];
        logic [3:0] rdy;
        logic v;
        logic [1:0] id;
        logic [7:0] f;
        int r;
        ta = '{5, 4, 0, 6};
        tb = '{7, 4, 9, 0};
        for (int i = 0; i < 24; i++) begin
            ta.push_back(int'($urandom_range(0, 15)));
            tb.push_back(int'($urandom_range(0, 15)));
        end
        for (int i = 0; i < ta.size(); i++) begin
            r = int'($urandom_range(0, 3));
            one_op(r, ta[i], tb[i], rdy, v, id, f);
            vectors++;
            if ({rdy, v, id, f} !==
                {4'b0001 << r, 1'b1, 2'(r), model(ta[i], tb[i])}) begin
                miscompares++;
                $display("FAIL arith a=%0d b=%0d got=%b want=%b",
                         ta[i], tb[i], {rdy, v, id, f},
                         {4'b0001 << r, 1'b1, 2'(r), model(ta[i], tb[i])});
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        logic [9:0] e;
        int k;
        do_reset();
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            exp_rdy = (c % 2 == 0) ? 4'b0001 << rr_pick(4'hF, m_ptr) : 4'b0;
            vectors++;
            if (req_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL rr_ready c=%0d got=%b want=%b",
                         c, req_ready, exp_rdy);
            end
            vectors++;
            if (rsp_valid !== 1'b0 + (c >= 2 && c % 2 == 0)) begin
                miscompares++;
                $display("FAIL rr_valid c=%0d got=%b", c, rsp_valid);
            end
            if (rsp_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if ({rsp_id, obs()} !== {e[9:8], model(e[7:4], e[3:0])}) begin
                    miscompares++;
                    $display("FAIL rr_rsp c=%0d got=%b want=%b", c,
                             {rsp_id, obs()}, {e[9:8], model(e[7:4], e[3:0])});
                end
            end
            k = -1;
            if (c % 2 == 0) begin
                k = rr_pick(4'hF, m_ptr);
                sb.push_back({2'(k), req_a[k*4 +: 4], req_b[k*4 +: 4]});
                m_ptr = (k + 1) % 4;
            end
            @(posedge clk);
            #1;
            if (k >= 0) begin
                req_a[k*4 +: 4] = 4'($urandom);
                req_b[k*4 +: 4] = 4'($urandom);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] snap;
        logic [9:0] e;
        int k;
        rsp_ready = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL bp_start got=%b want=1", rsp_valid);
        end
        snap = {rsp_valid, rsp_id, obs()};
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            if (snap !== {1'b1, e[9:8], model(e[7:4], e[3:0])}) begin
                miscompares++;
                $display("FAIL bp_rsp got=%b want=%b",
                         snap, {1'b1, e[9:8], model(e[7:4], e[3:0])});
            end
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #2;
            vectors++;
            if (req_ready !== 4'b0 || {rsp_valid, rsp_id, obs()} !== snap) begin
                miscompares++;
                $display("FAIL bp_hold c=%0d ready=%b rsp=%b want=%b",
                         c, req_ready, {rsp_valid, rsp_id, obs()}, snap);
            end
        end
        rsp_ready = 1'b1;
        #1;
        k = rr_pick(4'hF, m_ptr);
        vectors++;
        if (req_ready !== 4'b0001 << k) begin
            miscompares++;
            $display("FAIL bp_release_ready got=%b want=%b",
                     req_ready, 4'b0001 << k);
        end
        e = {2'(k), req_a[k*4 +: 4], req_b[k*4 +: 4]};
        m_ptr = (k + 1) % 4;
        sync();
        req_valid = '0;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drop got=%b want=0", rsp_valid);
        end
        sync();
        vectors++;
        if ({rsp_valid, rsp_id, obs()} !==
            {1'b1, e[9:8], model(e[7:4], e[3:0])}) begin
            miscompares++;
            $display("FAIL bp_next got=%b want=%b", {rsp_valid, rsp_id, obs()},
                     {1'b1, e[9:8], model(e[7:4], e[3:0])});
        end
        sync();
    endtask

    task automatic test_reset_mid_exec();
        int a1, b1;
        do_reset();
        req_valid     = 4'b0001;
        req_a[0 +: 4] = 4'd7;
        req_b[0 +: 4] = 4'd3;
        sync();
        req_valid     = 4'b0100;
        req_a[8 +: 4] = 4'd5;
        req_b[8 +: 4] = 4'd5;
        sync();
        vectors++;
        if ({rsp_valid, rsp_id, obs()} !== {1'b1, 2'd0, model(7, 3)}) begin
            miscompares++;
            $display("FAIL rst_pre_rsp got=%b want=%b",
                     {rsp_valid, rsp_id, obs()}, {1'b1, 2'd0, model(7, 3)});
        end
        sync();
        a1 = int'($urandom_range(1, 15));
        b1 = int'($urandom_range(1, 15));
        req_a[4 +: 4] = 4'(a1);
        req_b[4 +: 4] = 4'(b1);
        req_valid = 4'b1010;
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_id, obs()} !== 15'b0) begin
            miscompares++;
            $display("FAIL rst_mid got=%b want=0",
                     {req_ready, rsp_valid, rsp_id, obs()});
        end
        sync();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL rst_regrant got=%b want=0010", req_ready);
        end
        sync();
        req_valid = '0;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_stale got=%b want=0", rsp_valid);
        end
        sync();
        vectors++;
        if ({rsp_valid, rsp_id, obs()} !== {1'b1, 2'd1, model(a1, b1)}) begin
            miscompares++;
            $display("FAIL rst_after got=%b want=%b",
                     {rsp_valid, rsp_id, obs()}, {1'b1, 2'd1, model(a1, b1)});
        end
        sync();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_ptr       = 0;
        test_reset();
        test_single();
        test_arith();
        test_round_robin();
        test_backpressure();
        test_reset_mid_exec();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_scheduler.md
# mul_scheduler

Shares one combinational `multiplier` datapath between `req` independent requesters. Each requester uses a valid/ready handshake. A round-robin arbiter picks one requester, latches its operands, and runs one multiply. The block then presents the registered product and flags, tagged with the requester index, on a single response channel with backpressure. It sits between the issue logic and the shared arithmetic unit.

## Interface
- `bus`, 4: operand and result width in bits.
- `req`, 4: number of requesters; must be ≥ 2. `idw` = $clog2(req).
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  req: bit i set means requester i has an operation pending.
- `req_a`  in  req*bus: requester i operand a in bits [i*bus +: bus].
- `req_b`  in  req*bus: requester i operand b in bits [i*bus +: bus].
- `req_ready`  out  req: one-hot or zero; bit i set means requester i is accepted this cycle.
- `rsp_valid`  out  1: response registers hold a valid result.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_id`  out  idw: index of the requester that owns the response.
- `rsp_result`  out  bus: low `bus` bits of a*b.
- `rsp_overflow`, `rsp_zero`, `rsp_negative`, `rsp_carry_out`  out  1 each: registered flags.

## Operation
- FSM has three states: IDLE, EXEC, DONE.
- **Arbitration**
  - Pointer `ptr` has reset value 0.
  - Winner is the first index with `req_valid` set, searching ptr, ptr+1, …, req-1, then wrapping to 0.
  - After a grant to index k, `ptr` becomes (k+1) mod req.
- **Grant rules**
  - `req_ready[winner]` = 1 only when the FSM is in IDLE, or in DONE with `rsp_ready` = 1, and at least one `req_valid` bit is set. Otherwise `req_ready` is all zeros.
  - A requester holds its operands stable while valid and not ready.
  - Dropping `req_valid` after acceptance has no effect.
- **IDLE**
  - If any request is present: latch the winner's a, b and id, then go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC**
  - Latched operands drive the multiplier.
  - At the edge, result and flags are registered, `rsp_valid` is set to 1, and the FSM goes to DONE.
- **DONE**
  - All `rsp_*` outputs hold stable while `rsp_ready` = 0.
  - When `rsp_ready` = 1 and a request is present: accept it, then go to EXEC with `rsp_valid` cleared to 0.
  - When `rsp_ready` = 1 and no request is present: clear `rsp_valid` and go to IDLE.
- **Arithmetic**, with P = full 2*bus-bit product a*b:
  - result = P[bus-1:0]
  - carry_out = P[bus]
  - overflow = 1 iff a ≠ 0 and P ≥ 2^bus. Equivalently, (result / a) ≠ b.
  - zero = (a == 0) or (b == 0). This comes from the operands, not from the result.
  - negative = result[bus-1].
- **Reset**, asynchronous and valid in any state, including mid-EXEC or DONE:
  - FSM returns to IDLE and `ptr` = 0.
  - `rsp_valid`, `rsp_id`, `rsp_result` and all flags go to 0.
  - `req_ready` is 0 while `rst_n` = 0.
  - An in-flight operation is discarded and never reported.

## Timing
- Accept edge at end of cycle N; EXEC in cycle N+1; `rsp_valid` = 1 from cycle N+2.
- Best-case throughput is one operation every 2 cycles, back-to-back through DONE to EXEC.
- `req_ready` is combinational from `req_valid`, state, `ptr` and `rsp_ready`.
- All `rsp_*` outputs are registered.
- `rsp_valid` never deasserts without `rsp_ready` = 1 (or reset).
- At most one `req_ready` bit is high in any cycle.

## Test plan
- **Single request** (bus=4, req=4): requester 2 sends a=3, b=5.
  - `req_ready` = 4'b0100 in the accept cycle.
  - Two cycles later: `rsp_valid`=1, id=2, result=4'hF, overflow=0, carry_out=0, zero=0, negative=1.
- **Overflow and carry**:
  - a=5, b=7 → result=3, carry_out=0, overflow=1, zero=0.
  - a=4, b=4 → result=0, carry_out=1, overflow=1, zero=0.
- **Zero operand**: a=0, b=9 → result=0, zero=1, overflow=0, carry_out=0. Separately, b=0, a=6 → zero=1.
- **Round-robin**: all four `req_valid` held high, `rsp_ready`=1.
  - Grants occur in order 0, 1, 2, 3, 0, one accept every 2 cycles.
  - `rsp_id` follows the same sequence.
- **Backpressure**: hold `rsp_ready`=0 for 5 cycles with requests pending.
  - `rsp_*` stays constant and `req_ready`=0 throughout.
  - Raise `rsp_ready`: the next winner is accepted in that same cycle, and `rsp_valid` drops the following cycle.
- **Reset mid-EXEC**: pull `rst_n` low during EXEC.
  - All outputs go to 0 immediately, with no response for the dropped operation.
  - After release, with requesters 1 and 3 valid, requester 1 is granted first (`ptr`=0).
